// File: rtl/uart_inst_loader.sv
// uart_inst_loader
//   Receives RV32 instruction words from a host over an 8N1 UART line and
//   presents them to the cpu through a one-word valid/ready holding register.
//   Bytes arrive little-endian: the first byte of each group of four is the
//   instruction LSB.
//
// Ports
//   clk          in   1   system clock, rising edge
//   rst          in   1   asynchronous active-high reset
//   uart_rx      in   1   serial line from host, idles high, asynchronous
//   inst_out     out  32  held instruction word
//   inst_valid   out  1   holding register contains an unconsumed word
//   inst_ready   in   1   cpu takes inst_out this cycle when inst_valid=1
//   overrun      out  1   pulse: completed word dropped, holding register full
//   framing_err  out  1   pulse: stop bit sampled low
//
// RX state   | meaning
// -----------+--------------------------------------------------------
// S_IDLE     | line idle, waiting for a low level
// S_START    | timing to mid start bit to confirm it is not a glitch
// S_DATA     | sampling 8 data bits, LSB first, one per bit period
// S_STOP     | timing to mid stop bit; byte accepted or framing error

module uart_inst_loader #(
    parameter int unsigned CLKS_PER_BIT = 104
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx,
    output logic [31:0] inst_out,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic        overrun,
    output logic        framing_err
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t        r_state;
    logic          r_rx_meta;
    logic          r_rx_s;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic [1:0]    r_byte_idx;
    logic [23:0]   r_word_lo;
    logic          r_framing_err;
    logic [31:0]   r_inst_out;
    logic          r_inst_valid;
    logic          r_overrun;

    logic          w_stop_tick;
    logic          w_offer;
    logic [31:0]   w_word;

    // Synchronizer resets to the idle (high) line level so release from
    // reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= uart_rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    assign w_stop_tick = (r_state == S_STOP) && (r_cnt == CNT_LAST);
    // The fourth byte goes straight from the shifter into the holding
    // register, so only the lower three bytes need staging.
    assign w_offer     = w_stop_tick && r_rx_s && (r_byte_idx == 2'd3);
    assign w_word      = {r_shift, r_word_lo};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_bit_idx     <= 3'd0;
            r_shift       <= 8'h00;
            r_byte_idx    <= 2'd0;
            r_word_lo     <= 24'h0;
            r_framing_err <= 1'b0;
        end else begin
            r_framing_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!r_rx_s) begin
                        r_state <= S_START;
                        r_cnt   <= '0;
                    end
                end
                S_START: begin
                    if (r_cnt == CNT_HALF) begin
                        if (!r_rx_s) begin
                            r_state   <= S_DATA;
                            r_cnt     <= '0;
                            r_bit_idx <= 3'd0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt     <= '0;
                        r_shift   <= {r_rx_s, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    // Leaving at mid stop bit lets a following start bit be
                    // caught even with no idle gap between frames.
                    if (r_cnt == CNT_LAST) begin
                        r_state <= S_IDLE;
                        if (r_rx_s) begin
                            case (r_byte_idx)
                                2'd0:    r_word_lo[7:0]   <= r_shift;
                                2'd1:    r_word_lo[15:8]  <= r_shift;
                                2'd2:    r_word_lo[23:16] <= r_shift;
                                default: ;
                            endcase
                            r_byte_idx <= r_byte_idx + 2'd1;
                        end else begin
                            // A bad frame means byte alignment is suspect;
                            // restart the word at byte 0.
                            r_framing_err <= 1'b1;
                            r_byte_idx    <= 2'd0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inst_out   <= 32'h0;
            r_inst_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_offer) begin
                if (!r_inst_valid || inst_ready) begin
                    r_inst_out   <= w_word;
                    r_inst_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_inst_valid && inst_ready) begin
                r_inst_valid <= 1'b0;
            end
        end
    end

    assign inst_out    = r_inst_out;
    assign inst_valid  = r_inst_valid;
    assign overrun     = r_overrun;
    assign framing_err = r_framing_err;

endmodule

// File: tb/tb_uart_inst_loader.sv
// Bench for uart_inst_loader: serial frames are driven with exact bit
// timing, and a byte-level model predicts each byte's arrival cycle, word
// assembly and holding-register behaviour; all outputs are compared every
// cycle. Directed scenarios are pinned with literal expectations, then a
// randomized phase mixes good frames, bad stop bits, glitches and a
// randomly toggling ready.

module tb_uart_inst_loader;

    localparam int C   = 16;
    localparam int H   = C / 2;
    // Cycles from the edge after which a start bit is driven to the edge
    // that samples its stop bit: 2 sync flops, 1 detect, H+1 to mid start,
    // then 9 full bit periods.
    localparam int LAT = 4 + H + 9 * C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uart_rx = 1'b1;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic        inst_valid;
    logic        overrun;
    logic        framing_err;

    logic dir_ready = 1'b0;
    logic rnd_ready = 1'b0;
    logic rand_mode = 1'b0;
    assign inst_ready = rand_mode ? rnd_ready : dir_ready;

    uart_inst_loader #(.CLKS_PER_BIT(C)) dut (
        .clk         (clk),
        .rst         (rst),
        .uart_rx     (uart_rx),
        .inst_out    (inst_out),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .overrun     (overrun),
        .framing_err (framing_err)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    logic rdy_edge = 1'b0;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rdy_edge <= inst_ready;
    end

    typedef struct {
        int         t;
        bit         ok;
        logic [7:0] b;
    } arr_t;

    arr_t        arrq[$];
    logic [31:0] consumed[$];

    logic [31:0] m_out = 32'h0;
    logic        m_valid = 1'b0;
    logic        m_ov = 1'b0;
    logic        m_fe = 1'b0;
    int          m_idx = 0;
    logic [7:0]  m_bytes [0:3];
    arr_t        a_cur;
    bit          offer_cur;
    logic [31:0] w_cur;

    int errors = 0;
    int checks = 0;
    int n_ov = 0;
    int n_fe = 0;
    int n_vhi = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model and per-cycle comparison, evaluated half a cycle after each edge.
    always @(negedge clk) begin
        if (rst) begin
            m_valid = 1'b0;
            m_out   = 32'h0;
            m_ov    = 1'b0;
            m_fe    = 1'b0;
            m_idx   = 0;
            arrq.delete();
        end else begin
            m_ov      = 1'b0;
            m_fe      = 1'b0;
            offer_cur = 1'b0;
            if (arrq.size() > 0 && arrq[0].t == cyc) begin
                a_cur = arrq.pop_front();
                if (!a_cur.ok) begin
                    m_fe  = 1'b1;
                    m_idx = 0;
                end else begin
                    m_bytes[m_idx] = a_cur.b;
                    if (m_idx == 3) begin
                        offer_cur = 1'b1;
                        w_cur = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
                    end
                    m_idx = (m_idx + 1) % 4;
                end
            end
            if (m_valid && rdy_edge) consumed.push_back(m_out);
            if (offer_cur) begin
                if (!m_valid || rdy_edge) begin
                    m_out   = w_cur;
                    m_valid = 1'b1;
                end else begin
                    m_ov = 1'b1;
                end
            end else if (m_valid && rdy_edge) begin
                m_valid = 1'b0;
            end
        end
        chk("inst_out", inst_out, m_out);
        chk("inst_valid", {31'h0, inst_valid}, {31'h0, m_valid});
        chk("overrun", {31'h0, overrun}, {31'h0, m_ov});
        chk("framing_err", {31'h0, framing_err}, {31'h0, m_fe});
        if (overrun) n_ov++;
        if (framing_err) n_fe++;
        if (inst_valid) n_vhi++;
    end

    // One 8N1 frame, exactly 10*C cycles. A bad stop bit is held low only
    // past its sample point, then the line idles an extra bit period so the
    // receiver's post-frame re-arm sees a high line.
    task automatic send_frame(input logic [7:0] b, input bit good);
        @(posedge clk); #1;
        uart_rx = 1'b0;
        arrq.push_back('{t: cyc + LAT, ok: good, b: b});
        for (int i = 0; i < 8; i++) begin
            repeat (C) @(posedge clk);
            #1 uart_rx = b[i];
        end
        repeat (C) @(posedge clk);
        #1;
        if (good) begin
            uart_rx = 1'b1;
            repeat (C - 1) @(posedge clk);
        end else begin
            uart_rx = 1'b0;
            repeat (H + 4) @(posedge clk);
            #1 uart_rx = 1'b1;
            repeat (C - H - 5) @(posedge clk);
            repeat (C) @(posedge clk);
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_frame(w[8*k +: 8], 1'b1);
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1 uart_rx = 1'b1;
        repeat (n) @(posedge clk);
    endtask

    task automatic consume_one();
        @(posedge clk); #1 dir_ready = 1'b1;
        @(posedge clk); #1 dir_ready = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: got cycle %0d expected finish earlier", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int ov0, fe0, vh0, c0, tgt, guard;
        logic [31:0] wa, wb;

        // 1: reset with idle line
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("rst_inst_out", inst_out, 32'h0);
        chk("rst_valid", {31'h0, inst_valid}, 32'h0);
        chk("rst_overrun", {31'h0, overrun}, 32'h0);
        chk("rst_framing", {31'h0, framing_err}, 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (10) @(posedge clk);

        // 2: single word, cpu always ready
        dir_ready = 1'b1;
        vh0 = n_vhi; c0 = consumed.size();
        send_word(32'h00A00513);
        idle(10);
        chk("t2_valid_cycles", n_vhi - vh0, 1);
        chk("t2_consumed_n", consumed.size() - c0, 1);
        chk("t2_word", consumed[consumed.size()-1], 32'h00A00513);
        chk("t2_out_holds", inst_out, 32'h00A00513);

        // 3: cpu stalled, second word overruns
        @(posedge clk); #1 dir_ready = 1'b0;
        ov0 = n_ov;
        send_word(32'h00000013);
        send_word(32'h00100093);
        idle(10);
        chk("t3_overruns", n_ov - ov0, 1);
        chk("t3_held", inst_out, 32'h00000013);
        chk("t3_valid", {31'h0, inst_valid}, 32'h1);
        consume_one();
        chk("t3_consumed", consumed[consumed.size()-1], 32'h00000013);
        chk("t3_valid_after", {31'h0, inst_valid}, 32'h0);

        // 4: framing error resyncs byte index
        dir_ready = 1'b1;
        fe0 = n_fe; c0 = consumed.size();
        send_frame(8'hAA, 1'b1);
        send_frame(8'h55, 1'b0);
        send_word(32'h00000013);
        idle(10);
        chk("t4_framing", n_fe - fe0, 1);
        chk("t4_consumed_n", consumed.size() - c0, 1);
        chk("t4_word", consumed[consumed.size()-1], 32'h00000013);

        // 5: short glitch, then reset mid-byte with a partial word pending
        fe0 = n_fe; vh0 = n_vhi;
        @(posedge clk); #1 uart_rx = 1'b0;
        repeat (H / 2) @(posedge clk);
        #1 uart_rx = 1'b1;
        repeat (3 * C) @(posedge clk);
        chk("t5_glitch_fe", n_fe - fe0, 0);
        chk("t5_glitch_valid", n_vhi - vh0, 0);
        send_frame(8'hAA, 1'b1);
        send_frame(8'hBB, 1'b1);
        @(posedge clk); #1 uart_rx = 1'b0;
        repeat (C) @(posedge clk);
        #1 uart_rx = 1'b1;
        repeat (C) @(posedge clk);
        #1 uart_rx = 1'b0;
        repeat (H) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 uart_rx = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (C) @(posedge clk);
        c0 = consumed.size();
        send_word(32'h00500093);
        idle(10);
        chk("t5_consumed_n", consumed.size() - c0, 1);
        chk("t5_word", consumed[consumed.size()-1], 32'h00500093);

        // 6: ready rises in the exact cycle the next word is offered
        @(posedge clk); #1 dir_ready = 1'b0;
        wa = 32'h11223344; wb = 32'h55667788;
        ov0 = n_ov; c0 = consumed.size();
        send_word(wa);
        for (int k = 0; k < 3; k++) send_frame(wb[8*k +: 8], 1'b1);
        fork
            send_frame(wb[31:24], 1'b1);
            begin
                @(posedge clk); #2;
                tgt = arrq[arrq.size()-1].t;
                guard = 0;
                while (cyc != tgt - 1 && guard < LAT + 20) begin
                    @(posedge clk); #1;
                    guard++;
                end
                chk("t6_align", cyc, tgt - 1);
                dir_ready = 1'b1;
                @(posedge clk); #1 dir_ready = 1'b0;
            end
        join
        idle(5);
        chk("t6_overruns", n_ov - ov0, 0);
        chk("t6_held_b", inst_out, 32'h55667788);
        consume_one();
        chk("t6_consumed_n", consumed.size() - c0, 2);
        chk("t6_first", consumed[consumed.size()-2], 32'h11223344);
        chk("t6_second", consumed[consumed.size()-1], 32'h55667788);

        // Randomized traffic with random cpu backpressure
        rand_mode = 1'b1;
        for (int n = 0; n < 40; n++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind == 0) send_frame(8'($urandom), 1'b0);
            else if (kind == 1) idle($urandom_range(1, 30));
            else send_frame(8'($urandom), 1'b1);
        end
        idle(2 * C);
        rand_mode = 1'b0;
        dir_ready = 1'b1;
        repeat (10) @(posedge clk);
        chk("drain_valid", {31'h0, inst_valid}, 32'h0);
        chk("arrivals_left", arrq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : rnd
        forever begin
            @(posedge clk); #1;
            rnd_ready = 1'($urandom_range(0, 1));
        end
    end

endmodule
